loop_filter: RTL and testbench

LOOP_FILTER -- requirements
Module: loop_filter

---
 rtl/lf_pkg.sv | 46 ++++
 rtl/lf_lock_fsm.sv | 77 +++++++
 rtl/loop_filter.sv | 84 ++++++++
 tb/tb_loop_filter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lf_pkg.sv
// Shared widths, default thresholds, FSM encoding and small helpers for the loop filter.
package lf_pkg;

    localparam int unsigned IN_W    = 19;  // dpd_in: 9 int, 10 frac
    localparam int unsigned INTEG_W = 32;  // integrator: 12 int, 20 frac
    localparam int unsigned OUT_W   = 24;  // dco_word: 14 int, 10 frac
    localparam int unsigned CNT_W   = 5;   // lock counter width

    localparam logic [IN_W-1:0] LOCK_THR_DEF   = 19'd64;   // 0.0625
    localparam logic [IN_W-1:0] UNLOCK_THR_DEF = 19'd256;  // 0.25
    localparam int unsigned     LOCK_CNT_DEF   = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAcq    = 2'd1,
        StLocked = 2'd2,
        StHold   = 2'd3
    } lf_state_e;

    // Magnitude of a signed sample; the most negative code clamps to the largest positive one.
    function automatic logic [IN_W-1:0] abs_sat(input logic [IN_W-1:0] d);
        logic [IN_W-1:0] res;
        if (!d[IN_W-1]) begin
            res = d;
        end else if (d == {1'b1, {(IN_W-1){1'b0}}}) begin
            res = {1'b0, {(IN_W-1){1'b1}}};
        end else begin
            res = -d;
        end
        return res;
    endfunction

    // Gear shift: once locked, both gains drop by a factor of four, bottoming out at 2^-7.
    function automatic logic [2:0] gear(input logic [2:0] sel, input logic locked);
        logic [2:0] res;
        if (!locked) begin
            res = sel;
        end else if (sel >= 3'd5) begin
            res = 3'd7;
        end else begin
            res = sel + 3'd2;
        end
        return res;
    endfunction

endpackage

// File: rtl/lf_lock_fsm.sv
// Lock detector and acquisition/lock/hold state machine for the loop filter.
module lf_lock_fsm
    import lf_pkg::*;
#(
    parameter logic [IN_W-1:0] LOCK_THR   = LOCK_THR_DEF,
    parameter logic [IN_W-1:0] UNLOCK_THR = UNLOCK_THR_DEF,
    parameter int unsigned     LOCK_CNT   = LOCK_CNT_DEF
) (
    input  logic            clk,
    input  logic            rst_cnt,
    input  logic [IN_W-1:0] dpd_in,
    input  logic            dpd_valid,
    input  logic            openLoop,
    output logic [1:0]      state,
    output logic            lock
);

    localparam logic [CNT_W:0] LockCntV = (CNT_W + 1)'(LOCK_CNT);

    lf_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  mag;
    logic [CNT_W:0]   cnt_next;
    logic [CNT_W-1:0] cnt_sat;

    // Sample magnitude and the counter value this sample would produce.
    always_comb begin
        mag      = abs_sat(dpd_in);
        cnt_next = {1'b0, cnt_q} + 1'b1;
        cnt_sat  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // Next state and lock counter; openLoop overrides any sample arriving the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (openLoop) begin
            state_d = StHold;
            cnt_d   = '0;
        end else if (dpd_valid) begin
            if (state_q == StLocked) begin
                if (mag > UNLOCK_THR) begin
                    state_d = StAcq;
                end
            end else if (mag <= LOCK_THR) begin
                // IDLE and HOLD samples are handled exactly like ACQ samples.
                if (cnt_next >= LockCntV) begin
                    state_d = StLocked;
                    cnt_d   = '0;
                end else begin
                    state_d = StAcq;
                    cnt_d   = cnt_sat;
                end
            end else begin
                state_d = StAcq;
                cnt_d   = '0;
            end
        end else if (state_q == StHold) begin
            state_d = StAcq;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign lock  = (state_q == StLocked);

endmodule

// File: rtl/loop_filter.sv
// PI loop filter: DPD error in, DCO control word out, with gear-shifted gains once locked.
module loop_filter
    import lf_pkg::*;
#(
    parameter logic [IN_W-1:0] LOCK_THR   = LOCK_THR_DEF,
    parameter logic [IN_W-1:0] UNLOCK_THR = UNLOCK_THR_DEF,
    parameter int unsigned     LOCK_CNT   = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst_cnt,
    input  logic [IN_W-1:0]  dpd_in,
    input  logic             dpd_valid,
    input  logic             openLoop,
    input  logic [2:0]       kp_sel,
    input  logic [2:0]       ki_sel,
    output logic [OUT_W-1:0] dco_word,
    output logic             lf_valid,
    output logic             lock,
    output logic [1:0]       lf_state
);

    logic signed [INTEG_W-1:0] integ_q, integ_next;
    logic signed [INTEG_W-1:0] x, p_term, i_term;
    logic signed [INTEG_W:0]   acc_sum, out_sum;
    logic        [OUT_W-1:0]   dco_q, dco_next;
    logic                      valid_q;
    logic        [2:0]         kp_eff, ki_eff;
    logic                      update;

    lf_lock_fsm #(
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR),
        .LOCK_CNT   (LOCK_CNT)
    ) u_lock_fsm (
        .clk       (clk),
        .rst_cnt   (rst_cnt),
        .dpd_in    (dpd_in),
        .dpd_valid (dpd_valid),
        .openLoop  (openLoop),
        .state     (lf_state),
        .lock      (lock)
    );

    // Datapath: scale input to 12i20f, apply gains, saturate integrator, round to 14i10f.
    always_comb begin
        update  = dpd_valid && !openLoop;
        kp_eff  = gear(kp_sel, lock);
        ki_eff  = gear(ki_sel, lock);
        x       = {{(INTEG_W - IN_W - 10){dpd_in[IN_W-1]}}, dpd_in, 10'b0};
        p_term  = x >>> kp_eff;
        i_term  = x >>> ki_eff;
        acc_sum = {integ_q[INTEG_W-1], integ_q} + {i_term[INTEG_W-1], i_term};
        if (acc_sum[INTEG_W] != acc_sum[INTEG_W-1]) begin
            // Overflow: clamp toward the sign of the true (33-bit) result.
            integ_next = acc_sum[INTEG_W] ? {1'b1, {(INTEG_W-1){1'b0}}}
                                          : {1'b0, {(INTEG_W-1){1'b1}}};
        end else begin
            integ_next = acc_sum[INTEG_W-1:0];
        end
        out_sum  = {integ_next[INTEG_W-1], integ_next} + {p_term[INTEG_W-1], p_term}
                 + (INTEG_W + 1)'(512);
        // Bits [32:10] are the rounded result; one extra sign bit fills 24 bits.
        dco_next = {out_sum[INTEG_W], out_sum[INTEG_W:10]};
    end

    // Integrator, output word and valid strobe; all held when no sample is taken.
    always_ff @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            integ_q <= '0;
            dco_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= update;
            if (update) begin
                integ_q <= integ_next;
                dco_q   <= dco_next;
            end
        end
    end

    assign dco_word = dco_q;
    assign lf_valid = valid_q;

endmodule

// File: tb/tb_loop_filter.sv
// Self-checking bench for loop_filter: directed scenarios plus randomized traffic vs a model.
module tb_loop_filter;

    localparam logic [18:0] LT = 19'd64;
    localparam logic [18:0] UT = 19'd256;
    localparam int          LC = 16;

    logic        clk = 1'b0;
    logic        rst_cnt = 1'b1;
    logic [18:0] dpd_in = '0;
    logic        dpd_valid = 1'b0;
    logic        openLoop = 1'b0;
    logic [2:0]  kp_sel = '0;
    logic [2:0]  ki_sel = '0;
    logic [23:0] dco_word;
    logic        lf_valid;
    logic        lock;
    logic [1:0]  lf_state;

    loop_filter #(
        .LOCK_THR   (LT),
        .UNLOCK_THR (UT),
        .LOCK_CNT   (LC)
    ) dut (
        .clk       (clk),
        .rst_cnt   (rst_cnt),
        .dpd_in    (dpd_in),
        .dpd_valid (dpd_valid),
        .openLoop  (openLoop),
        .kp_sel    (kp_sel),
        .ki_sel    (ki_sel),
        .dco_word  (dco_word),
        .lf_valid  (lf_valid),
        .lock      (lock),
        .lf_state  (lf_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (states: 0 idle, 1 acquire, 2 locked, 3 hold).
    longint m_integ = 0;
    longint m_dco   = 0;
    int     m_state = 0;
    int     m_cnt   = 0;
    int     m_valid = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_shift(input longint a, input int k);
        longint div = longint'(1) << k;
        longint q = a / div;
        if (a < 0 && q * div != a) q = q - 1;
        return q;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint dco_now();
        return longint'($signed(dco_word));
    endfunction

    task automatic model_reset();
        m_integ = 0;
        m_dco   = 0;
        m_state = 0;
        m_cnt   = 0;
        m_valid = 0;
    endtask

    // One clock of the specified behaviour, using the inputs just applied.
    task automatic model_step(input int d, input bit v, input bit ol, input int kp, input int ki);
        int     mag;
        int     kpe;
        int     kie;
        bit     locked;
        longint x;
        longint inew;
        if (ol) begin
            m_state = 3;
            m_cnt   = 0;
            m_valid = 0;
        end else if (v) begin
            locked = (m_state == 2);
            kpe    = locked ? min_int(kp + 2, 7) : kp;
            kie    = locked ? min_int(ki + 2, 7) : ki;
            x      = longint'(d) * 1024;
            inew   = m_integ + floor_shift(x, kie);
            if (inew > 64'sd2147483647) inew = 64'sd2147483647;
            if (inew < -64'sd2147483648) inew = -64'sd2147483648;
            m_dco   = floor_shift(inew + floor_shift(x, kpe) + 512, 10);
            m_integ = inew;
            m_valid = 1;
            mag = (d < 0) ? ((d == -262144) ? 262143 : -d) : d;
            if (locked) begin
                if (mag > int'(UT)) m_state = 1;
            end else if (mag <= int'(LT)) begin
                if (m_cnt + 1 >= LC) begin
                    m_state = 2;
                    m_cnt   = 0;
                end else begin
                    m_state = 1;
                    m_cnt   = m_cnt + 1;
                end
            end else begin
                m_state = 1;
                m_cnt   = 0;
            end
        end else begin
            m_valid = 0;
            if (m_state == 3) m_state = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".dco"}, dco_now(), m_dco);
        check_eq({tag, ".valid"}, longint'(lf_valid), longint'(m_valid));
        check_eq({tag, ".lock"}, longint'(lock), longint'(m_state == 2));
        check_eq({tag, ".state"}, longint'(lf_state), longint'(m_state));
    endtask

    // Apply one cycle of stimulus, advance the model, compare just after the edge.
    task automatic step(input string tag, input int d, input bit v, input bit ol);
        dpd_in    = 19'(d);
        dpd_valid = v;
        openLoop  = ol;
        @(posedge clk);
        #1;
        model_step(d, v, ol, int'(kp_sel), int'(ki_sel));
        check_outputs(tag);
    endtask

    // Reset pulse between clock edges; outputs must clear without waiting for a clock.
    task automatic apply_reset(input string tag);
        dpd_valid = 1'b0;
        openLoop  = 1'b0;
        @(negedge clk);
        rst_cnt = 1'b1;
        #1;
        check_eq({tag, ".dco"}, dco_now(), 0);
        check_eq({tag, ".valid"}, longint'(lf_valid), 0);
        check_eq({tag, ".lock"}, longint'(lock), 0);
        check_eq({tag, ".state"}, longint'(lf_state), 0);
        #1;
        rst_cnt = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        int  d;
        bit  v;
        bit  ol;
        int  mode;

        repeat (2) @(posedge clk);
        #1;
        apply_reset("reset");

        // Single unit-ish sample with unity gains.
        kp_sel = 3'd0;
        ki_sel = 3'd0;
        step("first", 1024, 1'b1, 1'b0);
        check_eq("first_dco_2048", dco_now(), 2048);
        check_eq("first_state_acq", longint'(lf_state), 1);
        step("first_idle", 0, 1'b0, 1'b0);
        check_eq("first_valid_pulse", longint'(lf_valid), 0);

        // Positive saturation of the integrator.
        apply_reset("rst_sat");
        for (int i = 0; i < 10; i++) step("sat", 262143, 1'b1, 1'b0);
        check_eq("sat_dco", dco_now(), 2359295);
        check_eq("sat_no_wrap", longint'(dco_word[23]), 0);

        // Lock counting, interrupted once.
        apply_reset("rst_lock");
        step("lock_pre", 1000, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step("lock_a", 10, 1'b1, 1'b0);
        check_eq("lock_after15", longint'(lock), 0);
        step("lock_break", 100, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step("lock_b", 10, 1'b1, 1'b0);
        check_eq("lock_restart15", longint'(lock), 0);
        step("lock_b16", 10, 1'b1, 1'b0);
        check_eq("lock_after16", longint'(lock), 1);

        // Losing lock: the breaking sample still uses the geared gains.
        kp_sel = 3'd1;
        step("unlock", 300, 1'b1, 1'b0);
        check_eq("unlock_lock", longint'(lock), 0);
        check_eq("unlock_state", longint'(lf_state), 1);

        // Open loop beats a simultaneous sample; release returns to acquire.
        step("hold", 5000, 1'b1, 1'b1);
        check_eq("hold_state", longint'(lf_state), 3);
        check_eq("hold_valid", longint'(lf_valid), 0);
        step("hold_release", 0, 1'b0, 1'b0);
        check_eq("release_state", longint'(lf_state), 1);

        // Reach lock again, then reset asynchronously mid-lock.
        kp_sel = 3'd2;
        ki_sel = 3'd3;
        for (int i = 0; i < 16; i++) step("relock", -20, 1'b1, 1'b0);
        check_eq("relock", longint'(lock), 1);
        apply_reset("rst_midlock");
        kp_sel = 3'd0;
        ki_sel = 3'd0;
        step("post_reset", 1024, 1'b1, 1'b0);
        check_eq("post_reset_dco", dco_now(), 2048);

        // Randomized traffic: even blocks favour lockable magnitudes, odd blocks full range.
        for (int blk = 0; blk < 10; blk++) begin
            mode = blk % 2;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 15) == 0) kp_sel = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) ki_sel = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 499) == 0) apply_reset("rnd_rst");
                if (mode == 0) begin
                    if ($urandom_range(0, 9) != 0) d = int'($urandom_range(0, 128)) - 64;
                    else d = int'($urandom_range(0, 800)) - 400;
                end else begin
                    if ($urandom_range(0, 9) == 0) d = -262144;
                    else d = int'($urandom_range(0, 524287)) - 262144;
                end
                v  = ($urandom_range(0, 9) < 7);
                ol = ($urandom_range(0, 49) == 0);
                step("rnd", d, v, ol);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
